// File: rtl/turn_signal_sequencer.sv
// Tail-light sequencer controller: arbitrates left/right/hazard requests into one
// command and generates the step tick/index the lamp pattern block advances on.
module turn_signal_sequencer #(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned CANCEL_SEQS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic       left_cmd,
  output logic       right_cmd,
  output logic       hazard_cmd,
  output logic       tick,
  output logic [1:0] seq_step,
  output logic       busy,
  output logic       cancel_done
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SEQ_W = $clog2(CANCEL_SEQS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SEQ_W-1:0] SEQ_LIMIT = SEQ_W'(CANCEL_SEQS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEQ_W-1:0] seq, seq_nxt, seq_inc;
  logic [1:0]       step_nxt;
  logic             lock_l, lock_l_nxt;
  logic             lock_r, lock_r_nxt;
  logic             cancel_c;
  logic             haz, lft, rgt;
  logic             tick_c, boundary_c;

  // Effective requests; both turn levers at once are treated as hazard.
  assign haz = hazard_req | (left_req & right_req);
  assign lft = left_req & ~right_req & ~lock_l;
  assign rgt = right_req & ~left_req & ~lock_r;

  assign tick_c     = (state != IDLE) && (cnt == CNT_LAST);
  assign boundary_c = tick_c && (seq_step == 2'd3);
  assign seq_inc    = seq + SEQ_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      seq         <= '0;
      lock_l      <= 1'b0;
      lock_r      <= 1'b0;
      left_cmd    <= 1'b0;
      right_cmd   <= 1'b0;
      hazard_cmd  <= 1'b0;
      tick        <= 1'b0;
      seq_step    <= 2'd0;
      busy        <= 1'b0;
      cancel_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      seq         <= seq_nxt;
      lock_l      <= lock_l_nxt;
      lock_r      <= lock_r_nxt;
      left_cmd    <= (state_nxt == LEFT);
      right_cmd   <= (state_nxt == RIGHT);
      hazard_cmd  <= (state_nxt == HAZARD);
      tick        <= (state_nxt != IDLE) && (cnt_nxt == CNT_LAST);
      seq_step    <= step_nxt;
      busy        <= (state_nxt != IDLE);
      cancel_done <= cancel_c;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = tick_c ? '0 : cnt + CNT_W'(1);
    step_nxt   = tick_c ? seq_step + 2'd1 : seq_step;
    seq_nxt    = seq;
    cancel_c   = 1'b0;
    lock_l_nxt = lock_l & left_req;
    lock_r_nxt = lock_r & right_req;

    case (state)
      IDLE: begin
        if (haz)      state_nxt = HAZARD;
        else if (lft) state_nxt = LEFT;
        else if (rgt) state_nxt = RIGHT;
      end
      LEFT: begin
        if (haz) begin
          state_nxt = HAZARD;
        end else if (boundary_c) begin
          if ((seq_inc == SEQ_LIMIT) && left_req) begin
            state_nxt  = IDLE;
            lock_l_nxt = 1'b1;
            cancel_c   = 1'b1;
          end else if (rgt) begin
            state_nxt = RIGHT;
          end else if (left_req) begin
            seq_nxt = seq_inc;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RIGHT: begin
        if (haz) begin
          state_nxt = HAZARD;
        end else if (boundary_c) begin
          if ((seq_inc == SEQ_LIMIT) && right_req) begin
            state_nxt  = IDLE;
            lock_r_nxt = 1'b1;
            cancel_c   = 1'b1;
          end else if (lft) begin
            state_nxt = LEFT;
          end else if (right_req) begin
            seq_nxt = seq_inc;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HAZARD: begin
        // Hazard only yields at a sequence boundary and never auto-cancels.
        if (boundary_c && !haz) begin
          if (lft)      state_nxt = LEFT;
          else if (rgt) state_nxt = RIGHT;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Every entry, switch or idle cycle restarts the step timing from zero.
    if ((state_nxt != state) || (state_nxt == IDLE)) begin
      cnt_nxt  = '0;
      step_nxt = 2'd0;
      seq_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed bench for turn_signal_sequencer: stimulus pushes cycle-stamped expected
// output vectors into a scoreboard that a negedge monitor pops and compares.
module tb_turn_signal_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       left_req, right_req, hazard_req;
  logic       left_cmd, right_cmd, hazard_cmd, tick, busy, cancel_done;
  logic [1:0] seq_step;

  turn_signal_sequencer #(.TICK_DIV(4), .CANCEL_SEQS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .left_req    (left_req),
    .right_req   (right_req),
    .hazard_req  (hazard_req),
    .left_cmd    (left_cmd),
    .right_cmd   (right_cmd),
    .hazard_cmd  (hazard_cmd),
    .tick        (tick),
    .seq_step    (seq_step),
    .busy        (busy),
    .cancel_done (cancel_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    string       name;
    logic [7:0]  vec;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          drain = 1'b0;
  bit          drained = 1'b0;
  logic [7:0]  act;
  logic [2:0]  cmds;

  assign act  = {left_cmd, right_cmd, hazard_cmd, tick, seq_step, busy, cancel_done};
  assign cmds = {left_cmd, right_cmd, hazard_cmd};

  always @(posedge clk) cyc <= cyc + 1;

  // Vector: {left, right, hazard, tick, seq_step[1:0], busy, cancel_done}
  function automatic logic [7:0] mk(bit l, bit r, bit h, bit tk, logic [1:0] st, bit cd);
    return {l, r, h, tk, st, (l | r | h), cd};
  endfunction

  function automatic void exp_at(int unsigned at, string name, logic [7:0] v);
    exp_t x;
    x.at = at;
    x.name = name;
    x.vec = v;
    sb.push_back(x);
  endfunction

  task automatic wait_cyc(int unsigned n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  // Monitor: compares whenever the scoreboard head is due this cycle, plus invariants.
  always @(negedge clk) begin
    n_checks++;
    if (busy !== (left_cmd | right_cmd | hazard_cmd)) begin
      n_fail++;
      $display("FAIL busy_inv @cycle %0d: busy=%b cmds=%b", cyc, busy, cmds);
    end
    n_checks++;
    if ((cmds & (cmds - 3'd1)) !== 3'd0) begin
      n_fail++;
      $display("FAIL onehot_inv @cycle %0d: cmds=%b", cyc, cmds);
    end
    while (sb.size() > 0 && (sb[0].at < cyc || drain)) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: check due at cycle %0d never evaluated (now %0d)", e.name, e.at, cyc);
    end
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: got %b required %b (l r h tick step busy cancel)",
                 e.name, cyc, act, e.vec);
      end
    end
    if (drain) drained = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    left_req = 1'b1;
    right_req = 1'b0;
    hazard_req = 1'b0;

    // Scenario 1: reset holds outputs low, then LEFT with tick every 4 cycles.
    exp_at(3,  "s1_reset_a",    mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(9,  "s1_reset_b",    mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(11, "s1_left_entry", mk(1, 0, 0, 0, 2'd0, 0));
    exp_at(12, "s1_no_tick",    mk(1, 0, 0, 0, 2'd0, 0));
    exp_at(14, "s1_tick0",      mk(1, 0, 0, 1, 2'd0, 0));
    exp_at(15, "s1_step1",      mk(1, 0, 0, 0, 2'd1, 0));
    exp_at(18, "s1_tick1",      mk(1, 0, 0, 1, 2'd1, 0));
    exp_at(19, "s1_step2",      mk(1, 0, 0, 0, 2'd2, 0));
    exp_at(23, "s1_step3",      mk(1, 0, 0, 0, 2'd3, 0));
    exp_at(26, "s1_boundary",   mk(1, 0, 0, 1, 2'd3, 0));
    exp_at(27, "s1_wrap",       mk(1, 0, 0, 0, 2'd0, 0));
    wait_cyc(10);
    reset = 1'b1;

    // Scenario 2: auto-cancel at the 2nd boundary, lockout until lever released.
    wait_cyc(27);
    exp_at(42, "s2_last_tick",  mk(1, 0, 0, 1, 2'd3, 0));
    exp_at(43, "s2_cancel",     mk(0, 0, 0, 0, 2'd0, 1));
    exp_at(44, "s2_cancel_end", mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(50, "s2_locked",     mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(51, "s2_released",   mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(52, "s2_reentry",    mk(1, 0, 0, 0, 2'd0, 0));
    wait_cyc(50);
    left_req = 1'b0;
    wait_cyc(51);
    left_req = 1'b1;

    // Scenario 3: switch request at step 1 waits for the boundary.
    wait_cyc(52);
    exp_at(60, "s3_left_holds", mk(1, 0, 0, 0, 2'd2, 0));
    exp_at(67, "s3_boundary",   mk(1, 0, 0, 1, 2'd3, 0));
    exp_at(68, "s3_right",      mk(0, 1, 0, 0, 2'd0, 0));
    exp_at(71, "s3_right_tick", mk(0, 1, 0, 1, 2'd0, 0));
    exp_at(72, "s3_right_s1",   mk(0, 1, 0, 0, 2'd1, 0));
    wait_cyc(56);
    left_req = 1'b0;
    right_req = 1'b1;

    // Scenario 4: back to LEFT, then hazard preempts mid-sequence.
    wait_cyc(72);
    exp_at(84,  "s4_left",       mk(1, 0, 0, 0, 2'd0, 0));
    exp_at(92,  "s4_left_s2",    mk(1, 0, 0, 0, 2'd2, 0));
    exp_at(93,  "s4_hazard",     mk(0, 0, 1, 0, 2'd0, 0));
    exp_at(96,  "s4_haz_tick",   mk(0, 0, 1, 1, 2'd0, 0));
    exp_at(97,  "s4_haz_s1",     mk(0, 0, 1, 0, 2'd1, 0));
    exp_at(108, "s4_haz_bound",  mk(0, 0, 1, 1, 2'd3, 0));
    exp_at(109, "s4_idle",       mk(0, 0, 0, 0, 2'd0, 0));
    right_req = 1'b0;
    left_req = 1'b1;
    wait_cyc(92);
    hazard_req = 1'b1;
    wait_cyc(97);
    hazard_req = 1'b0;
    left_req = 1'b0;

    // Scenario 5: both levers act as hazard, no auto-cancel, exit at boundary.
    wait_cyc(110);
    exp_at(111, "s5_hazard",     mk(0, 0, 1, 0, 2'd0, 0));
    exp_at(127, "s5_bound1",     mk(0, 0, 1, 0, 2'd0, 0));
    exp_at(143, "s5_bound2",     mk(0, 0, 1, 0, 2'd0, 0));
    exp_at(159, "s5_bound3",     mk(0, 0, 1, 0, 2'd0, 0));
    exp_at(170, "s5_dropped",    mk(0, 0, 1, 1, 2'd2, 0));
    exp_at(174, "s5_last_tick",  mk(0, 0, 1, 1, 2'd3, 0));
    exp_at(175, "s5_idle",       mk(0, 0, 0, 0, 2'd0, 0));
    left_req = 1'b1;
    right_req = 1'b1;
    wait_cyc(165);
    left_req = 1'b0;
    right_req = 1'b0;

    // Scenario 6: asynchronous reset between edges while in HAZARD.
    wait_cyc(180);
    exp_at(183, "s6_hazard",     mk(0, 0, 1, 0, 2'd0, 0));
    exp_at(185, "s6_async_rst",  mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(186, "s6_in_reset",   mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(190, "s6_idle_a",     mk(0, 0, 0, 0, 2'd0, 0));
    exp_at(195, "s6_idle_b",     mk(0, 0, 0, 0, 2'd0, 0));
    hazard_req = 1'b1;
    wait_cyc(185);
    #2;
    reset = 1'b0;
    hazard_req = 1'b0;
    wait_cyc(188);
    reset = 1'b1;

    wait_cyc(200);
    drain = 1'b1;
    for (int i = 0; i < 5 && !drained; i++) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
